// File: rtl/decimal_pkg.sv
// Shared types and constants for the decimal entry path.
package decimal_pkg;

    localparam int unsigned RADIX_C     = 10;
    localparam int unsigned DIGIT_MAX_C = 9;

    typedef logic [3:0] bcd_t;
    typedef logic [7:0] bin_t;

    typedef enum logic [1:0] {
        StIdle,
        StEntry1,
        StEntry2,
        StConvert
    } state_e;

endpackage

// File: rtl/bcd_accum.sv
// Iterative tens/ones to binary converter: loads ones, then adds RADIX once per tens count.
module bcd_accum
    import decimal_pkg::*;
#(
    parameter int unsigned RADIX = RADIX_C
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  bcd_t tens,
    input  bcd_t ones,
    input  logic abort,
    output logic done,
    output bin_t result
);

    logic active_q;
    bin_t acc_q;
    bcd_t cnt_q;

    // Accumulator, remaining tens count and run flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (abort) begin
            active_q <= 1'b0;
        end else if (start) begin
            active_q <= 1'b1;
            acc_q    <= {4'b0000, ones};
            cnt_q    <= tens;
        end else if (active_q) begin
            if (cnt_q != '0) begin
                acc_q <= acc_q + bin_t'(RADIX);
                cnt_q <= cnt_q - 4'd1;
            end else begin
                active_q <= 1'b0;
            end
        end
    end

    // Result is ready in the cycle the tens count has run out.
    always_comb begin
        done   = active_q && (cnt_q == '0);
        result = acc_q;
    end

endmodule

// File: rtl/decimal_entry.sv
// Two-digit BCD keypad entry with sticky error flag and iterative conversion to binary.
module decimal_entry
    import decimal_pkg::*;
#(
    parameter int unsigned RADIX      = RADIX_C,
    parameter int unsigned MAX_DIGITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    input  logic       commit,
    input  logic       clear,
    output logic [3:0] entry_tens,
    output logic [3:0] entry_ones,
    output logic [7:0] num_out,
    output logic       num_valid,
    output logic       busy,
    output logic       error
);

    state_e      state_q, state_d;
    logic        accept_digit, set_error, clr_all, start, abort, finish;
    logic        done;
    bin_t        result;
    int unsigned held;

    bcd_accum #(
        .RADIX (RADIX)
    ) u_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .tens   (entry_tens),
        .ones   (entry_ones),
        .abort  (abort),
        .done   (done),
        .result (result)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath controls; clear beats commit beats digit.
    always_comb begin
        state_d      = state_q;
        accept_digit = 1'b0;
        set_error    = 1'b0;
        clr_all      = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        finish       = 1'b0;
        held         = (state_q == StEntry1) ? 1 : (state_q == StEntry2) ? 2 : 0;
        if (clear) begin
            clr_all = 1'b1;
            abort   = (state_q == StConvert);
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StEntry1, StEntry2: begin
                    if (commit && state_q != StIdle) begin
                        start   = 1'b1;
                        state_d = StConvert;
                    end else if (digit_valid) begin
                        if (digit_in > 4'(DIGIT_MAX_C) || held >= MAX_DIGITS) begin
                            set_error = 1'b1;
                        end else begin
                            accept_digit = 1'b1;
                            state_d      = (state_q == StIdle) ? StEntry1 : StEntry2;
                        end
                    end
                end
                StConvert: begin
                    // Digits and commits are silently ignored while converting.
                    if (done) begin
                        finish  = 1'b1;
                        state_d = StIdle;
                    end
                end
            endcase
        end
    end

    // Registered outputs: entry digits, converted value, strobes and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_tens <= '0;
            entry_ones <= '0;
            num_out    <= '0;
            num_valid  <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
        end else begin
            num_valid <= finish;
            if (start) begin
                busy <= 1'b1;
            end else if (finish || abort) begin
                busy <= 1'b0;
            end
            if (clr_all) begin
                error <= 1'b0;
            end else if (set_error) begin
                error <= 1'b1;
            end
            if (clr_all || finish) begin
                entry_tens <= '0;
                entry_ones <= '0;
            end else if (accept_digit) begin
                entry_tens <= entry_ones;
                entry_ones <= digit_in;
            end
            if (finish) begin
                num_out <= result;
            end
        end
    end

endmodule

// File: doc/decimal_entry.md
# decimal_entry

Sequential decimal-to-binary entry block: the input-side counterpart of the binary-to-two-digit display path. It collects up to two BCD digits from a keypad or switch strobe and shows the pending digits for the seven-segment drivers. On commit, it converts tens/ones to an 8-bit binary value by iterative add-ten and hands the result to the datapath with a one-cycle valid pulse.

## Interface
Parameters:
- RADIX, 10, decimal base; added once per tens count during conversion
- MAX_DIGITS, 2, digits held before further digits are rejected

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- digit_in  input  4  BCD digit, sampled when digit_valid=1
- digit_valid  input  1  single-cycle digit strobe
- commit  input  1  single-cycle request to convert pending entry
- clear  input  1  single-cycle discard of entry and error
- entry_tens  output  4  pending tens digit (0 when fewer than 2 digits)
- entry_ones  output  4  pending ones digit
- num_out  output  8  last converted binary value, held until next conversion
- num_valid  output  1  one-cycle pulse when num_out updates
- busy  output  1  high while converting
- error  output  1  sticky; set by invalid digit (>9) or third digit

## Operation
- States: IDLE (0 digits), ENTRY1 (1 digit), ENTRY2 (2 digits), CONVERT.
- Accepted digit shifts left: tens<=ones, ones<=digit_in. IDLE->ENTRY1, ENTRY1->ENTRY2.
- digit_in > 9: digit dropped, error<=1, state unchanged.
- digit_valid in ENTRY2: digit dropped, error<=1.
- digit_valid in CONVERT: ignored silently; error unchanged.
- commit in ENTRY1/ENTRY2: acc<=ones (8 bit), cnt<=tens, go CONVERT, busy<=1.
- commit in IDLE or CONVERT: ignored.
- CONVERT, each cycle:
  - cnt!=0: acc<=acc+RADIX, cnt<=cnt-1.
  - cnt==0: num_out<=acc, num_valid<=1, entry digits<=0, busy<=0, state IDLE.
- Range 0..99; acc never exceeds 99, so no overflow in 8 bits.
- Priority within one cycle: clear > commit > digit_valid.
  - clear: entry digits<=0, error<=0, state IDLE. In CONVERT it aborts; num_out keeps its old value and no num_valid pulse is issued.
  - commit together with digit_valid: commit wins, digit dropped, no error.
- error does not block entry or commit; only clear or reset removes it.

## Timing
- Reset (async, rst_n=0): state IDLE; entry_tens=0, entry_ones=0, num_out=0, num_valid=0, busy=0, error=0, acc=0, cnt=0.
- All outputs are registered. entry_* update on the edge that samples digit_valid.
- busy rises the edge after commit is sampled.
- num_valid is high for exactly one cycle, tens+1 cycles after the commit edge. Minimum latency is 1 cycle (tens=0); maximum is 10 (tens=9).
- num_out changes only on the cycle num_valid rises.
- A back-to-back commit is accepted only once the state is back in IDLE/ENTRY with new digits.

## Structure
- Shared package decimal_pkg: state enum (IDLE, ENTRY1, ENTRY2, CONVERT), RADIX_C=10, DIGIT_MAX_C=9, BCD digit typedef (4 bit), binary value typedef (8 bit).
- One sub-module is natural: bcd_accum, the iterative tens/ones-to-binary converter.
  - Ports: start, tens, ones, abort, done, result.
  - The top owns the entry FSM, error flag and output registers.
- entry_tens/entry_ones connect directly to the existing sevenseg instances.

## Test plan
- Reset mid-conversion: digits 4,7, commit, then drop rst_n at cycle 2 -> all outputs 0 immediately, state IDLE, no num_valid.
- Digits 4 then 7, commit -> entry_tens=4, entry_ones=7 before commit. busy for 5 cycles, num_valid one cycle at commit+5, num_out=47; entry then reads 0/0.
- Single digit 0, commit -> num_valid at commit+1, num_out=0. Then digits 9,9, commit -> num_out=99 at commit+10.
- Digit 12 (invalid) in IDLE -> error=1, entry 0/0. Digits 3,5,8 -> third digit rejected, entry 3/5, error stays 1. Commit -> num_out=35. Clear -> error=0.
- Digits 6,2, commit, clear at commit+3 -> no num_valid, num_out keeps previous 35, busy=0 next cycle.
- Same cycle: commit with digit_valid=1 (digit 5) in ENTRY1 holding 8 -> num_out=8, digit 5 dropped, error=0. Commit in IDLE -> no busy, no num_valid.
